// File: rtl/demux_route_sequencer.sv
// demux_route_sequencer
//   Command stage in front of the 1-to-16 demux. It buffers {select, bit}
//   commands in a small circular FIFO. It replays each command onto S/IN for
//   max(DWELL,1) cycles, then drives one IN=0 gap cycle before the next route
//   so that the demux outputs never glitch between routes.
//
// Parameters
//   DEPTH    command FIFO entries (power of two, >= 2)
//   DWELL_W  width of DWELL
//
// Ports
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   CMD_VALID  command present on CMD_SEL/CMD_BIT
//   CMD_READY  FIFO can accept (COUNT < DEPTH), combinational from COUNT
//   CMD_SEL    demux channel for the command
//   CMD_BIT    data bit to route
//   DWELL      hold time in cycles, sampled when a command is popped
//   S          registered select to the demux
//   IN         registered data bit to the demux
//   BUSY       high while a command is being held or in its gap cycle
//   COUNT      FIFO occupancy
module demux_route_sequencer #(
   parameter int DEPTH   = 4,
   parameter int DWELL_W = 4
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     CMD_VALID,
   output logic                     CMD_READY,
   input  logic [3:0]               CMD_SEL,
   input  logic                     CMD_BIT,
   input  logic [DWELL_W-1:0]       DWELL,
   output logic [3:0]               S,
   output logic                     IN,
   output logic                     BUSY,
   output logic [$clog2(DEPTH):0]   COUNT
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t               state, state_nxt;
   logic [4:0]           mem [DEPTH];
   logic [PTR_W-1:0]     rd_ptr, wr_ptr;
   logic [CNT_W-1:0]     count;
   logic [DWELL_W-1:0]   cnt, cnt_nxt;
   logic [3:0]           s_nxt;
   logic                 in_nxt;
   logic                 push, pop;
   logic [4:0]           head;

   // Ready looks only at the registered count, so a full FIFO refuses a push
   // even on the edge where it also pops.
   assign CMD_READY = (count < CNT_W'(DEPTH));
   assign push      = CMD_VALID && CMD_READY;
   assign head      = mem[rd_ptr];
   assign COUNT     = count;
   assign BUSY      = (state != IDLE);

   // A new command is loaded from IDLE or at the end of the gap cycle.
   assign pop = ((state == IDLE) || (state == GAP)) && (count != '0);

   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= {CMD_SEL, CMD_BIT};
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         S     <= '0;
         IN    <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         S     <= s_nxt;
         IN    <= in_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      s_nxt     = S;
      in_nxt    = 1'b0;
      cnt_nxt   = cnt;
      case (state)
         IDLE, GAP: begin
            if (pop) begin
               s_nxt     = head[4:1];
               in_nxt    = head[0];
               cnt_nxt   = (DWELL == '0) ? DWELL_W'(1) : DWELL;
               state_nxt = HOLD;
            end else begin
               state_nxt = IDLE;
            end
         end
         HOLD: begin
            in_nxt = IN;
            if (cnt == DWELL_W'(1)) begin
               in_nxt    = 1'b0;
               state_nxt = GAP;
            end else begin
               cnt_nxt = cnt - DWELL_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
